drenador_salidas: RTL and testbench
===================================

# drenador_salidas

Egress-side drain for the four output FIFOs written by the routing arbiter. It pops one word per cycle from whichever output FIFO is non-empty, using round-robin fairness. Each word goes into a single-entry output register with a valid/ready handshake toward the downstream consumer. It keeps a per-port count of drained words for the testbench and the status logic.

## Interface
- DATA_WIDTH, 10, width of a FIFO word; bits [9:8] carry the destination field, and the block passes them through unmodified.
- CNT_WIDTH, 8, width of each per-port drained-word counter.
- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- empty_p0..empty_p3  input  1 each  output-FIFO empty flags.
- data_p0..data_p3  input  DATA_WIDTH each  output-FIFO head words (show-ahead: valid whenever the matching empty flag is 0).
- ready_in  input  1  downstream can accept data_out this cycle.
- pop_p0..pop_p3  output  1 each  pop strobes to the output FIFOs; combinational; at most one high per cycle.
- data_out  output  DATA_WIDTH  registered egress word.
- valid_out  output  1  data_out holds a word not yet accepted.
- cnt_p0..cnt_p3  output  CNT_WIDTH each  words drained per port.
- idle  output  1  high when all empty_pX = 1 and valid_out = 0.

## Operation
- Slot free: `free = !valid_out || ready_in`.
- Eligible port X: `empty_pX == 0`.
- Round-robin pointer `last` is 2 bits and holds the last port served.
- Search order is `last+1, last+2, last+3, last`, mod 4.
- When `free` is high and any port is eligible, assert pop on the first eligible port in search order; otherwise assert no pop.
- On a popped cycle, at the clock edge:
  - data_out <= data_pX;
  - valid_out <= 1;
  - last <= X;
  - cnt_pX <= cnt_pX + 1, wrapping from 2^CNT_WIDTH-1 to 0.
- When `valid_out && ready_in` and nothing is popped, valid_out <= 0.
- data_out then keeps its last value.
- While `valid_out && !ready_in`:
  - data_out and valid_out hold;
  - all pops are 0.
- Pops depend only on the empties, `last` and `free`. The almost-full state of the egress consumer is expressed solely through ready_in.
- A single eligible port is served every cycle it is non-empty; fairness applies only among simultaneously eligible ports.

## Timing
- Reset values (reset_L = 0 at an edge):
  - valid_out = 0;
  - data_out = 0;
  - last = 3, so port 0 has first priority after reset;
  - cnt_p0..cnt_p3 = 0.
- While reset_L = 0, all pop_pX are forced to 0 combinationally. No FIFO is popped in a reset cycle.
- Reset mid-transfer discards any held word and does not retry it.
- Latency: a pop in cycle N produces valid_out = 1 with that word in cycle N+1.
- Throughput: one word per cycle while ready_in stays high.
- Back-to-back handoff: accept and pop may occur in the same cycle (`valid_out && ready_in`, port eligible). The register reloads and valid_out stays 1 with no bubble.
- ready_in low with valid_out = 0 does not block a pop; the slot is free.
- The FIFO empty flag rises at the edge after its last pop. The block does not speculate and pops that FIFO at most once per cycle.
- Counter wrap is silent; there is no saturation flag.
- idle is combinational from the empties and valid_out.

## Test plan
- **Reset then single port:**
  - Stimulus: hold reset_L = 0 for 2 cycles, then release. Load FIFO2 with 0x2A5, 0x2A6; ready_in = 1.
  - Required: pop_p2 high for 2 consecutive cycles; data_out = 0x2A5 then 0x2A6 on the next cycles; cnt_p2 = 2; idle = 1 afterwards.
- **Round-robin fairness:**
  - Stimulus: all four FIFOs hold 3 words each; ready_in = 1.
  - Required: pop order 0,1,2,3,0,1,2,3,0,1,2,3; every cnt_pX = 3; valid_out high for 12 consecutive cycles.
- **Backpressure:**
  - Stimulus: FIFO0 holds 0x0F1, 0x0F2; ready_in = 0 from the cycle after the first pop for 4 cycles.
  - Required: data_out stays 0x0F1, valid_out stays 1, all pops 0 during the stall. When ready_in returns to 1, pop_p0 occurs in the same cycle and data_out = 0x0F2 on the next cycle.
- **Skip empty ports:**
  - Stimulus: only FIFO1 and FIFO3 are non-empty, 2 words each; last = 3 after reset.
  - Required: order 1,3,1,3; pop_p0 and pop_p2 never asserted.
- **Counter wrap:**
  - Stimulus: drain 257 words from FIFO0.
  - Required: cnt_p0 = 1 at the end; other counters stay 0.
- **Reset mid-operation:**
  - Stimulus: reset_L = 0 while valid_out = 1, data_out = 0x3C3, cnt_p3 = 5.
  - Required: next cycle valid_out = 0, data_out = 0, cnt_p3 = 0; no pop during reset. The first pop after release goes to the lowest-numbered non-empty port.

Source files
------------

// File: rtl/drenador_salidas.sv
// -----------------------------------------------------------------------------
// drenador_salidas
//
// Egress drain for the four output FIFOs of the routing arbiter. Every cycle
// the single-entry egress register can take a word, one non-empty FIFO is
// popped in round-robin order, starting after the port served last. The popped
// word is loaded into the egress register and offered downstream with a
// valid/ready handshake. A free-running counter per port tracks how many words
// have been drained from it.
//
// Ports
//   clk                 rising-edge clock
//   reset_L             synchronous, active-low reset
//   empty_p0..empty_p3  FIFO empty flags (head word valid while 0)
//   data_p0..data_p3    FIFO head words (show-ahead)
//   ready_in            downstream accepts data_out this cycle
//   pop_p0..pop_p3      combinational pop strobes, at most one high
//   data_out            registered egress word
//   valid_out           data_out holds a word not yet accepted
//   cnt_p0..cnt_p3      words drained per port, wrapping
//   idle                all FIFOs empty and egress register empty
// -----------------------------------------------------------------------------
module drenador_salidas #(
    parameter int DATA_WIDTH = 10,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  empty_p0,
    input  logic                  empty_p1,
    input  logic                  empty_p2,
    input  logic                  empty_p3,
    input  logic [DATA_WIDTH-1:0] data_p0,
    input  logic [DATA_WIDTH-1:0] data_p1,
    input  logic [DATA_WIDTH-1:0] data_p2,
    input  logic [DATA_WIDTH-1:0] data_p3,
    input  logic                  ready_in,
    output logic                  pop_p0,
    output logic                  pop_p1,
    output logic                  pop_p2,
    output logic                  pop_p3,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [CNT_WIDTH-1:0]  cnt_p0,
    output logic [CNT_WIDTH-1:0]  cnt_p1,
    output logic [CNT_WIDTH-1:0]  cnt_p2,
    output logic [CNT_WIDTH-1:0]  cnt_p3,
    output logic                  idle
);

    localparam int NUM_PORTS = 4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [1:0]            last_q,  last_d;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_PORTS];

    // ------------------------------------------------------------------
    // Port bundling so the arbiter can index by port number
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0]  eligible;
    logic [DATA_WIDTH-1:0] head_word [NUM_PORTS];

    assign eligible = {~empty_p3, ~empty_p2, ~empty_p1, ~empty_p0};

    always_comb begin
        head_word[0] = data_p0;
        head_word[1] = data_p1;
        head_word[2] = data_p2;
        head_word[3] = data_p3;
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // The slot is free when the register is empty or is being drained
    // this cycle, so an accept and a reload can happen together.
    // ------------------------------------------------------------------
    logic       slot_free;
    logic       grant_found;
    logic [1:0] grant_idx;
    logic       pop_fire;
    logic [3:0] pop_vec;

    assign slot_free = !valid_q || ready_in;

    always_comb begin
        logic [1:0] cand;
        // NOTE: every variable assigned in an always_comb gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = last_q;
        cand        = last_q;
        // Search last+1, last+2, last+3, then last itself; the 2-bit sum
        // wraps mod 4, and k = 4 lands back on last.
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = last_q + 2'(k);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Reset gates the pop strobes so no FIFO loses a word during a reset
    // cycle; the egress register is cleared at the same edge.
    assign pop_fire = reset_L && slot_free && grant_found;
    assign pop_vec  = pop_fire ? (4'b0001 << grant_idx) : 4'b0000;

    assign pop_p0 = pop_vec[0];
    assign pop_p1 = pop_vec[1];
    assign pop_p2 = pop_vec[2];
    assign pop_p3 = pop_vec[3];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (pop_fire) begin
            data_d             = head_word[grant_idx];
            valid_d            = 1'b1;
            last_d             = grant_idx;
            // Counter wraps silently at 2^CNT_WIDTH.
            cnt_d[grant_idx]   = cnt_q[grant_idx] + CNT_WIDTH'(1);
        end else if (valid_q && ready_in) begin
            // Word accepted with nothing to replace it; data_q keeps its
            // last value, only the valid flag drops.
            valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State register with synchronous active-low reset. last resets to 3
    // so port 0 is first in the search order after reset. A word held at
    // reset is dropped, not retried.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (!reset_L) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 2'd3;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign cnt_p0    = cnt_q[0];
    assign cnt_p1    = cnt_q[1];
    assign cnt_p2    = cnt_q[2];
    assign cnt_p3    = cnt_q[3];
    assign idle      = empty_p0 && empty_p1 && empty_p2 && empty_p3 && !valid_q;

endmodule

// File: tb/tb_drenador_salidas.sv
// -----------------------------------------------------------------------------
// tb_drenador_salidas
//
// Bench for drenador_salidas. Four queue-based show-ahead FIFO models feed the
// DUT. Each directed test loads words and pushes the expected pop port and
// the expected egress word into scoreboard queues; a monitor running on the
// falling edge pops and compares whenever the DUT pops a FIFO or hands off a
// word. Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_drenador_salidas;

    localparam int DW = 10;
    localparam int CW = 8;

    logic          clk;
    logic          reset_L;
    logic          empty_p0, empty_p1, empty_p2, empty_p3;
    logic [DW-1:0] data_p0, data_p1, data_p2, data_p3;
    logic          ready_in;
    logic          pop_p0, pop_p1, pop_p2, pop_p3;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [CW-1:0] cnt_p0, cnt_p1, cnt_p2, cnt_p3;
    logic          idle;

    drenador_salidas #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .empty_p0  (empty_p0),
        .empty_p1  (empty_p1),
        .empty_p2  (empty_p2),
        .empty_p3  (empty_p3),
        .data_p0   (data_p0),
        .data_p1   (data_p1),
        .data_p2   (data_p2),
        .data_p3   (data_p3),
        .ready_in  (ready_in),
        .pop_p0    (pop_p0),
        .pop_p1    (pop_p1),
        .pop_p2    (pop_p2),
        .pop_p3    (pop_p3),
        .data_out  (data_out),
        .valid_out (valid_out),
        .cnt_p0    (cnt_p0),
        .cnt_p1    (cnt_p1),
        .cnt_p2    (cnt_p2),
        .cnt_p3    (cnt_p3),
        .idle      (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Bookkeeping and scoreboard
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] fq0[$];
    logic [DW-1:0] fq1[$];
    logic [DW-1:0] fq2[$];
    logic [DW-1:0] fq3[$];

    int            exp_port[$];
    logic [DW-1:0] exp_data[$];

    logic [3:0] pops_s = 4'b0000;
    int         valid_run = 0;
    int         max_run   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic refresh();
        empty_p0 = (fq0.size() == 0);
        empty_p1 = (fq1.size() == 0);
        empty_p2 = (fq2.size() == 0);
        empty_p3 = (fq3.size() == 0);
        data_p0  = empty_p0 ? '0 : fq0[0];
        data_p1  = empty_p1 ? '0 : fq1[0];
        data_p2  = empty_p2 ? '0 : fq2[0];
        data_p3  = empty_p3 ? '0 : fq3[0];
    endtask

    task automatic load(input int port, input logic [DW-1:0] w);
        case (port)
            0: fq0.push_back(w);
            1: fq1.push_back(w);
            2: fq2.push_back(w);
            default: fq3.push_back(w);
        endcase
        refresh();
    endtask

    function automatic bit all_empty();
        return fq0.size() == 0 && fq1.size() == 0 && fq2.size() == 0 && fq3.size() == 0;
    endfunction

    // Advance one clock: apply the pops seen at the preceding falling edge
    // to the FIFO models, then present the new head words.
    task automatic tick();
        logic [DW-1:0] tmp;
        @(posedge clk);
        #1;
        if (pops_s[0] && fq0.size() > 0) tmp = fq0.pop_front();
        if (pops_s[1] && fq1.size() > 0) tmp = fq1.pop_front();
        if (pops_s[2] && fq2.size() > 0) tmp = fq2.pop_front();
        if (pops_s[3] && fq3.size() > 0) tmp = fq3.pop_front();
        refresh();
    endtask

    task automatic drain(input int budget, input string name);
        int  i;
        bit  done;
        i    = 0;
        done = 0;
        while (!done && i < budget) begin
            if (exp_port.size() == 0 && exp_data.size() == 0 && !valid_out && all_empty())
                done = 1;
            else begin
                tick();
                i++;
            end
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic apply_reset();
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares pops and handoffs against the scoreboard queues
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        int            p;
        logic [DW-1:0] w;
        pops_s = {pop_p3, pop_p2, pop_p1, pop_p0};
        if (valid_out) valid_run++;
        else valid_run = 0;
        if (valid_run > max_run) max_run = valid_run;

        if (!reset_L) begin
            check("pop_in_reset", 32'(pops_s), 32'd0);
        end else begin
            if (pops_s != 4'b0000) begin
                check("pop_onehot", 32'($onehot(pops_s)), 32'd1);
                if (exp_port.size() == 0) begin
                    check("unexpected_pop", 32'(pops_s), 32'd0);
                end else begin
                    p = exp_port.pop_front();
                    check("pop_port", 32'(pops_s), 32'(4'b0001 << p));
                end
            end
            if (valid_out && ready_in) begin
                if (exp_data.size() == 0) begin
                    check("unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    w = exp_data.pop_front();
                    check("egress_word", 32'(data_out), 32'(w));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        logic [DW-1:0] w;

        reset_L  = 1'b0;
        ready_in = 1'b0;
        refresh();

        // Reset state after two reset edges
        tick();
        tick();
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data",  32'(data_out),  32'd0);
        check("rst_cnts",  32'({cnt_p0, cnt_p1, cnt_p2, cnt_p3}), 32'd0);
        check("rst_idle",  32'(idle),      32'd1);
        reset_L = 1'b1;

        // Single port: FIFO2 with two words
        ready_in = 1'b1;
        load(2, 10'h2A5);
        load(2, 10'h2A6);
        exp_port.push_back(2); exp_data.push_back(10'h2A5);
        exp_port.push_back(2); exp_data.push_back(10'h2A6);
        drain(20, "single_drain");
        check("single_cnt2", 32'(cnt_p2), 32'd2);
        check("single_idle", 32'(idle),   32'd1);

        // Round-robin fairness: three words in each FIFO
        apply_reset();
        max_run = 0;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 4; p++) begin
                w = 10'(p * 256 + 16 * k + p);
                load(p, w);
                exp_port.push_back(p);
                exp_data.push_back(w);
            end
        end
        drain(40, "rr_drain");
        check("rr_cnts", 32'({cnt_p0, cnt_p1, cnt_p2, cnt_p3}), 32'h0303_0303);
        check("rr_valid_run", 32'(max_run), 32'd12);

        // Backpressure on FIFO0
        apply_reset();
        load(0, 10'h0F1);
        load(0, 10'h0F2);
        exp_port.push_back(0); exp_data.push_back(10'h0F1);
        exp_port.push_back(0); exp_data.push_back(10'h0F2);
        tick();
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_hold_data",  32'(data_out), 32'h0F1);
            check("bp_hold_valid", 32'(valid_out), 32'd1);
            check("bp_no_pop", 32'({pop_p3, pop_p2, pop_p1, pop_p0}), 32'd0);
            tick();
        end
        ready_in = 1'b1;
        @(negedge clk);
        check("bp_resume_pop", 32'(pop_p0), 32'd1);
        tick();
        @(negedge clk);
        check("bp_second_word", 32'(data_out), 32'h0F2);
        drain(20, "bp_drain");

        // Skip empty ports: only FIFO1 and FIFO3 hold words
        apply_reset();
        load(1, 10'h151); load(1, 10'h152);
        load(3, 10'h3B1); load(3, 10'h3B2);
        exp_port.push_back(1); exp_data.push_back(10'h151);
        exp_port.push_back(3); exp_data.push_back(10'h3B1);
        exp_port.push_back(1); exp_data.push_back(10'h152);
        exp_port.push_back(3); exp_data.push_back(10'h3B2);
        drain(20, "skip_drain");
        check("skip_cnts", 32'({cnt_p0, cnt_p1, cnt_p2, cnt_p3}), 32'h0002_0002);

        // Counter wrap: 257 words from FIFO0
        apply_reset();
        for (int i = 0; i < 257; i++) begin
            w = 10'(i & 255);
            load(0, w);
            exp_port.push_back(0);
            exp_data.push_back(w);
        end
        drain(400, "wrap_drain");
        check("wrap_cnt0",   32'(cnt_p0), 32'd1);
        check("wrap_others", 32'({cnt_p1, cnt_p2, cnt_p3}), 32'd0);

        // Reset mid-operation: five words through FIFO3, last one held
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            w = 10'(10'h3BF + i);
            load(3, w);
            exp_port.push_back(3);
            exp_data.push_back(w);
        end
        for (int i = 0; i < 5; i++) tick();
        ready_in = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", 32'(valid_out), 32'd1);
        check("mid_pre_data",  32'(data_out),  32'h3C3);
        check("mid_pre_cnt3",  32'(cnt_p3),    32'd5);
        tick();
        reset_L = 1'b0;
        load(2, 10'h2D2);
        load(1, 10'h1D1);
        tick();
        check("mid_valid", 32'(valid_out), 32'd0);
        check("mid_data",  32'(data_out),  32'd0);
        check("mid_cnt3",  32'(cnt_p3),    32'd0);
        exp_data.delete();
        reset_L  = 1'b1;
        ready_in = 1'b1;
        exp_port.push_back(1); exp_data.push_back(10'h1D1);
        exp_port.push_back(2); exp_data.push_back(10'h2D2);
        drain(20, "mid_drain");
        check("mid_final_cnts", 32'({cnt_p0, cnt_p1, cnt_p2, cnt_p3}), 32'h0001_0100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
